// File: rtl/mask_centroid_pkg.sv
// rtl/mask_centroid_pkg.sv - shared widths and state encodings for the mask centroid block
package mask_centroid_pkg;

    localparam int SUM_W = 28;
    localparam int CNT_W = 19;
    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_X,
        DIV_Y,
        DIV_DONE
    } div_state_t;

    typedef enum logic {
        WAIT_SOF,
        ACCUM
    } raster_state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle, first bit on the start edge
module seq_divider
    import mask_centroid_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic [SUM_W-1:0] quotient,
    output logic             done
);

    logic             run_q, run_d;
    logic [4:0]       left_q, left_d;
    logic [SUM_W-1:0] dvd_q, dvd_d;
    logic [SUM_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] dsr_q, dsr_d;
    logic [SUM_W-1:0] src_dvd;
    logic [CNT_W-1:0] src_rem;
    logic [CNT_W-1:0] src_dsr;
    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   diff;
    logic             ge;

    always_comb begin
        run_d  = run_q;
        left_d = left_q;
        dvd_d  = dvd_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        // The start cycle works on the incoming operands directly so no cycle is spent loading.
        src_dvd = start ? dividend : dvd_q;
        src_rem = start ? '0 : rem_q;
        src_dsr = start ? divisor : dsr_q;
        trial   = {src_rem, src_dvd[SUM_W-1]};
        diff    = trial - {1'b0, src_dsr};
        ge      = (trial >= {1'b0, src_dsr});
        if (start || run_q) begin
            dvd_d  = {src_dvd[SUM_W-2:0], 1'b0};
            rem_d  = CNT_W'(ge ? diff : trial);
            quo_d  = start ? {{(SUM_W-1){1'b0}}, ge} : {quo_q[SUM_W-2:0], ge};
            dsr_d  = src_dsr;
            run_d  = start || (left_q != 5'd1);
            left_d = start ? 5'(SUM_W - 1) : left_q - 5'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q  <= 1'b0;
            left_q <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else begin
            run_q  <= run_d;
            left_q <= left_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
        end
    end

    // High in the cycle whose closing edge writes the final quotient bit.
    assign done     = run_q && (left_q == 5'd1);
    assign quotient = quo_q;

endmodule

// File: rtl/mask_centroid.sv
// rtl/mask_centroid.sv - per-frame mask moments and centroid via one shared sequential divider
module mask_centroid
    import mask_centroid_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pixel_valid,
    input  logic             frame_start,
    input  logic [7:0]       mask,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic [CNT_W-1:0] pixel_count,
    output logic             detected,
    output logic             pos_valid,
    output logic             busy
);

    localparam logic [9:0]       COL_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0]       ROW_LAST = 9'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);

    raster_state_t    rs_q, rs_d;
    div_state_t       ds_q, ds_d;
    logic [9:0]       col_q, col_d;
    logic [8:0]       row_q, row_d;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] snap_x_q, snap_x_d, snap_y_q, snap_y_d;
    logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;
    logic             first_q, first_d;
    logic [POS_W-1:0] x_res_q, x_res_d;
    logic [POS_W-1:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             det_q, det_d;
    logic             pv_q, pv_d;

    logic             take, hit, last_px;
    logic [9:0]       cur_col;
    logic [8:0]       cur_row;
    logic [SUM_W-1:0] acc_x, acc_y;
    logic [CNT_W-1:0] acc_n;
    logic             div_start, div_done;
    logic [SUM_W-1:0] div_dividend, div_quo;
    logic             unused_bits;

    always_comb begin
        rs_d    = rs_q;
        col_d   = col_q;
        row_d   = row_q;
        sum_x_d = sum_x_q;
        sum_y_d = sum_y_q;
        cnt_d   = cnt_q;
        take    = pixel_valid && (frame_start || (rs_q == ACCUM));
        hit     = mask[7];
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
        acc_x   = (frame_start ? '0 : sum_x_q) + (hit ? SUM_W'(cur_col) : '0);
        acc_y   = (frame_start ? '0 : sum_y_q) + (hit ? SUM_W'(cur_row) : '0);
        acc_n   = (frame_start ? '0 : cnt_q) + CNT_W'(hit);
        last_px = take && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        if (take) begin
            rs_d = ACCUM;
            if (last_px) begin
                col_d   = '0;
                row_d   = '0;
                sum_x_d = '0;
                sum_y_d = '0;
                cnt_d   = '0;
            end else begin
                sum_x_d = acc_x;
                sum_y_d = acc_y;
                cnt_d   = acc_n;
                if (cur_col == COL_LAST) begin
                    col_d = '0;
                    row_d = cur_row + 9'd1;
                end else begin
                    col_d = cur_col + 10'd1;
                    row_d = cur_row;
                end
            end
        end
    end

    always_comb begin
        ds_d         = ds_q;
        snap_x_d     = snap_x_q;
        snap_y_d     = snap_y_q;
        snap_cnt_d   = snap_cnt_q;
        first_d      = first_q;
        x_res_d      = x_res_q;
        x_pos_d      = x_pos_q;
        y_pos_d      = y_pos_q;
        pix_cnt_d    = pix_cnt_q;
        det_d        = det_q;
        pv_d         = 1'b0;
        div_start    = 1'b0;
        div_dividend = (ds_q == DIV_Y) ? snap_y_q : snap_x_q;
        case (ds_q)
            DIV_IDLE: begin
                // A frame ending while a division runs is dropped here by design.
                if (last_px) begin
                    snap_x_d   = acc_x;
                    snap_y_d   = acc_y;
                    snap_cnt_d = acc_n;
                    first_d    = 1'b1;
                    ds_d       = DIV_X;
                end
            end
            DIV_X: begin
                if (first_q) begin
                    first_d = 1'b0;
                    if (snap_cnt_q < MIN_CNT) begin
                        ds_d = DIV_DONE;
                    end else begin
                        div_start = 1'b1;
                    end
                end else if (div_done) begin
                    first_d = 1'b1;
                    ds_d    = DIV_Y;
                end
            end
            DIV_Y: begin
                if (first_q) begin
                    first_d   = 1'b0;
                    div_start = 1'b1;
                    x_res_d   = div_quo[POS_W-1:0];
                end else if (div_done) begin
                    ds_d = DIV_DONE;
                end
            end
            default: begin
                ds_d      = DIV_IDLE;
                pv_d      = 1'b1;
                pix_cnt_d = snap_cnt_q;
                det_d     = (snap_cnt_q >= MIN_CNT);
                if (snap_cnt_q >= MIN_CNT) begin
                    x_pos_d = x_res_q;
                    y_pos_d = div_quo[POS_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rs_q       <= WAIT_SOF;
            ds_q       <= DIV_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            cnt_q      <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_cnt_q <= '0;
            first_q    <= 1'b0;
            x_res_q    <= '0;
            x_pos_q    <= '0;
            y_pos_q    <= '0;
            pix_cnt_q  <= '0;
            det_q      <= 1'b0;
            pv_q       <= 1'b0;
        end else begin
            rs_q       <= rs_d;
            ds_q       <= ds_d;
            col_q      <= col_d;
            row_q      <= row_d;
            sum_x_q    <= sum_x_d;
            sum_y_q    <= sum_y_d;
            cnt_q      <= cnt_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            snap_cnt_q <= snap_cnt_d;
            first_q    <= first_d;
            x_res_q    <= x_res_d;
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            pix_cnt_q  <= pix_cnt_d;
            det_q      <= det_d;
            pv_q       <= pv_d;
        end
    end

    seq_divider u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (snap_cnt_q),
        .quotient (div_quo),
        .done     (div_done)
    );

    assign unused_bits = ^{mask[6:0], div_quo[SUM_W-1:POS_W]};
    assign x_pos       = x_pos_q;
    assign y_pos       = y_pos_q;
    assign pixel_count = pix_cnt_q;
    assign detected    = det_q;
    assign pos_valid   = pv_q;
    assign busy        = (ds_q != DIV_IDLE);

endmodule

// File: tb/tb_mask_centroid.sv
// tb/tb_mask_centroid.sv - directed frames with a scoreboard of expected centroid results
module tb_mask_centroid;

    localparam int H    = 104;
    localparam int V    = 56;
    localparam int MINP = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        pixel_valid;
    logic        frame_start;
    logic [7:0]  mask;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic [18:0] pixel_count;
    logic        detected;
    logic        pos_valid;
    logic        busy;

    typedef struct {
        int x;
        int y;
        int n;
        int det;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   model_x = 0;
    int   model_y = 0;
    logic pv_prev = 1'b0;

    mask_centroid #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
        .clock       (clock),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .mask        (mask),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pixel_count (pixel_count),
        .detected    (detected),
        .pos_valid   (pos_valid),
        .busy        (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drives one frame (or its first 'rows' rows) with a rectangular blob and queues the expected result.
    task automatic send_frame(input int rows, input int x0, input int x1, input int y0, input int y1);
        longint sx = 0;
        longint sy = 0;
        int     n  = 0;
        exp_t   e;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < H; c++) begin
                logic skin;
                skin = (c >= x0) && (c <= x1) && (r >= y0) && (r <= y1);
                if ($urandom_range(0, 15) == 0) begin
                    pixel_valid = 1'b0;
                    frame_start = 1'b1;
                    mask        = 8'hFF;
                    @(posedge clock);
                    #1;
                end
                pixel_valid = 1'b1;
                frame_start = (r == 0) && (c == 0);
                if (skin) mask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h80;
                else      mask = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h00;
                if (skin) begin
                    sx += c;
                    sy += r;
                    n++;
                end
                if (r == V - 1 && c == H - 1) begin
                    e.n   = n;
                    e.det = (n >= MINP) ? 1 : 0;
                    if (n >= MINP) begin
                        model_x = int'(sx / n);
                        model_y = int'(sy / n);
                    end
                    e.x   = model_x;
                    e.y   = model_y;
                    e.acc = cyc + 1;
                    exp_q.push_back(e);
                end
                @(posedge clock);
                #1;
            end
        end
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        mask        = 8'h00;
    endtask

    task automatic stray_pixels(input int cnt);
        pixel_valid = 1'b1;
        frame_start = 1'b0;
        mask        = 8'hFF;
        repeat (cnt) @(posedge clock);
        #1;
        pixel_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (pv_prev) check("pv_width", {31'b0, pos_valid}, 0);
        pv_prev = pos_valid;
        if (pos_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pv_spurious", {31'b0, pos_valid}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("x_pos", {22'b0, x_pos}, mon_e.x);
                check("y_pos", {22'b0, y_pos}, mon_e.y);
                check("pixel_count", {13'b0, pixel_count}, mon_e.n);
                check("detected", {31'b0, detected}, mon_e.det);
                check("latency", cyc - mon_e.acc, (mon_e.det != 0) ? 57 : 2);
                check("busy_end", {31'b0, busy}, 0);
            end
        end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > 80) begin
            check("pv_timeout", {31'b0, pos_valid}, 1);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        reset       = 1'b1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        mask        = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_x", {22'b0, x_pos}, 0);
        check("rst_y", {22'b0, y_pos}, 0);
        check("rst_cnt", {13'b0, pixel_count}, 0);
        check("rst_det", {31'b0, detected}, 0);
        check("rst_pv", {31'b0, pos_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        stray_pixels(150);
        check("sof_idle", {31'b0, busy}, 0);

        send_frame(V, 100, 100, 50, 50);
        check("busy_start", {31'b0, busy}, 1);
        send_frame(V, 20, 29, 10, 19);
        send_frame(V, -1, -2, -1, -2);

        send_frame(30, 50, 59, 5, 14);
        send_frame(V, 30, 33, 40, 43);

        send_frame(V, 10, 11, 10, 11);
        send_frame(V, 100, 101, 52, 53);

        send_frame(V, 60, 69, 20, 29);
        repeat (20) @(posedge clock);
        #1;
        check("busy_div", {31'b0, busy}, 1);
        reset = 1'b1;
        exp_q.delete();
        model_x = 0;
        model_y = 0;
        #1;
        check("mid_rst_x", {22'b0, x_pos}, 0);
        check("mid_rst_y", {22'b0, y_pos}, 0);
        check("mid_rst_cnt", {13'b0, pixel_count}, 0);
        check("mid_rst_det", {31'b0, detected}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_pv", {31'b0, pos_valid}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        stray_pixels(200);
        check("post_rst_idle", {31'b0, busy}, 0);
        send_frame(V, 40, 41, 30, 30);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clock);
        #1;
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
